// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
//
// Shared definitions for the SRAM sequencing controller and the behavioural
// 64K x 16 SRAM it drives. Both sides import this package so that bus widths
// and wait-state counts cannot drift apart.
//
// Contents:
//   SRAM_AW / SRAM_DW      address and data width of the SRAM
//   DEF_RD_WAIT            strobe cycles for a read  (SRAM latches dout on 2nd edge)
//   DEF_WR_WAIT            strobe cycles for a write (SRAM commits on 3rd edge)
//   state_t                controller state encoding
//   cnt_width()            width of the wait-state counter
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int SRAM_AW     = 16;
    localparam int SRAM_DW     = 16;
    localparam int DEF_RD_WAIT = 2;
    localparam int DEF_WR_WAIT = 3;

    // IDLE : waiting for a request, arbiter active
    // RD   : read strobes asserted, counting RD_WAIT cycles
    // CAP  : strobes released, SRAM output captured into the owner's rdata
    // WR   : write strobes asserted, counting WR_WAIT cycles
    // REC  : recovery cycle with strobes released after a write
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_REC  = 3'd4
    } state_t;

    // Counter must be able to hold max(RD_WAIT, WR_WAIT); never narrower than 1.
    function automatic int cnt_width(input int rd_wait, input int wr_wait);
        int m;
        m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sram_arb.sv
// -----------------------------------------------------------------------------
// sram_arb
//
// Two-requester arbiter for the SRAM controller.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   a_req     in   port A request
//   b_req     in   port B request
//   rr        in   0 = fixed priority A over B, 1 = round-robin on contention
//   grant_en  in   controller is able to accept a transaction this cycle
//   grant     out  one-hot grant, bit 0 = A, bit 1 = B (zero when not enabled)
//   last_b    out  side granted most recently (0 = A, 1 = B)
//
// The grant is a combinational function of the requests and the registered
// pointer; the controller registers everything that leaves the block, so no
// request input reaches an SRAM pin without passing through a flop.
// last_b doubles as the transaction owner in the controller: it is updated on
// exactly the edge that starts a transaction and holds until the next grant.
// -----------------------------------------------------------------------------
module sram_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       b_req,
    input  logic       rr,
    input  logic       grant_en,
    output logic [1:0] grant,
    output logic       last_b
);

    logic last_b_reg;
    logic [1:0] grant_next;

    always_comb begin
        grant_next = 2'b00;
        if (grant_en) begin
            if (a_req && b_req) begin
                // On contention round-robin hands the grant to whoever did not
                // win last time; fixed priority always favours A.
                if (rr && !last_b_reg) begin
                    grant_next = 2'b10;
                end else begin
                    grant_next = 2'b01;
                end
            end else if (a_req) begin
                grant_next = 2'b01;
            end else if (b_req) begin
                grant_next = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_b_reg <= 1'b0;
        end else if (grant_next != 2'b00) begin
            last_b_reg <= grant_next[1];
        end
    end

    assign grant  = grant_next;
    assign last_b = last_b_reg;

endmodule

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//
// Sequencing controller and two-port arbiter in front of a 64K x 16
// asynchronous-style SRAM model with internal edge counters. One request is
// granted at a time; the controller holds the active-low strobes for exactly
// the number of cycles the SRAM needs and then releases them for at least one
// cycle so the SRAM's internal counter clears before the next access.
//
// Parameters:
//   AW, DW      address / data width (must match the SRAM)
//   RD_WAIT     strobe cycles for a read
//   WR_WAIT     strobe cycles for a write
//   RR          0 = fixed priority A over B, 1 = round-robin on contention
//
// Ports (port B mirrors port A):
//   clk, rst_n                 clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  request, write flag, address, write data
//   a_ack                      one-cycle pulse: request accepted, inputs taken
//   a_rvalid                   one-cycle pulse: a_rdata valid
//   a_rdata                    read data, held until the next A read
//   sram_ce_n/oe_n/we_n        SRAM strobes (OE is low for writes as well)
//   sram_lb_n/ub_n             byte lanes, always enabled
//   sram_addr/sram_din         SRAM address / write data
//   sram_dout                  SRAM read data (registered inside the SRAM)
//   busy                       high whenever the controller is not IDLE
//
// Timing with defaults (T0 = edge that accepts a request):
//   read : strobes low T0..T2, capture at T3, next accept T4
//   write: strobes low T0..T3, recovery T3..T4, next accept T5
// -----------------------------------------------------------------------------
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW      = SRAM_AW,
    parameter int DW      = SRAM_DW,
    parameter int RD_WAIT = DEF_RD_WAIT,
    parameter int WR_WAIT = DEF_WR_WAIT,
    parameter int RR      = 0
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_lb_n,
    output logic          sram_ub_n,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,

    output logic          busy
);

    localparam int CW = cnt_width(RD_WAIT, WR_WAIT);

    // Terminal counts: the counter starts at 0 on state entry, so the edge
    // that sees LAST is the one ending the final strobe cycle.
    localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_WAIT - 1);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;

    logic          ce_n_reg;
    logic          oe_n_reg;
    logic          we_n_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] din_reg;

    logic          a_ack_reg;
    logic          b_ack_reg;
    logic          a_rvalid_reg;
    logic          b_rvalid_reg;
    logic [DW-1:0] a_rdata_reg;
    logic [DW-1:0] b_rdata_reg;

    logic [1:0]    grant;
    logic          owner_b;
    logic          grant_en;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // ------------------------------------------------------------------
    // Arbitration: only consulted while IDLE. The arbiter's last-grant
    // pointer is also the owner of the transaction in flight.
    // ------------------------------------------------------------------
    assign grant_en = (state_reg == ST_IDLE);

    sram_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .b_req    (b_req),
        .rr       (RR != 0),
        .grant_en (grant_en),
        .grant    (grant),
        .last_b   (owner_b)
    );

    // Winner's request fields, captured on the accepting edge.
    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (grant[1]) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: state, wait counter, strobes and return datapath.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            ce_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            we_n_reg     <= 1'b1;
            addr_reg     <= '0;
            din_reg      <= '0;
            a_ack_reg    <= 1'b0;
            b_ack_reg    <= 1'b0;
            a_rvalid_reg <= 1'b0;
            b_rvalid_reg <= 1'b0;
            a_rdata_reg  <= '0;
            b_rdata_reg  <= '0;
        end else begin
            // Handshake pulses last a single cycle.
            a_ack_reg    <= 1'b0;
            b_ack_reg    <= 1'b0;
            a_rvalid_reg <= 1'b0;
            b_rvalid_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        a_ack_reg <= grant[0];
                        b_ack_reg <= grant[1];
                        addr_reg  <= sel_addr;
                        din_reg   <= sel_wdata;
                        ce_n_reg  <= 1'b0;
                        oe_n_reg  <= 1'b0;
                        we_n_reg  <= ~sel_we;
                        cnt_reg   <= '0;
                        state_reg <= sel_we ? ST_WR : ST_RD;
                    end
                end

                ST_RD: begin
                    if (cnt_reg == RD_LAST) begin
                        ce_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_CAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_CAP: begin
                    // The SRAM latched its output on the last strobe edge;
                    // strobes stay high here, which also clears its counter.
                    if (owner_b) begin
                        b_rdata_reg  <= sram_dout;
                        b_rvalid_reg <= 1'b1;
                    end else begin
                        a_rdata_reg  <= sram_dout;
                        a_rvalid_reg <= 1'b1;
                    end
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end

                ST_WR: begin
                    if (cnt_reg == WR_LAST) begin
                        ce_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        we_n_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_REC;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_REC: begin
                    // Mandatory CE-high cycle; the SRAM would otherwise carry
                    // its edge count into the next access.
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    ce_n_reg  <= 1'b1;
                    oe_n_reg  <= 1'b1;
                    we_n_reg  <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sram_ce_n = ce_n_reg;
    assign sram_oe_n = oe_n_reg;
    assign sram_we_n = we_n_reg;
    assign sram_lb_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_addr = addr_reg;
    assign sram_din  = din_reg;

    assign a_ack     = a_ack_reg;
    assign b_ack     = b_ack_reg;
    assign a_rvalid  = a_rvalid_reg;
    assign b_rvalid  = b_rvalid_reg;
    assign a_rdata   = a_rdata_reg;
    assign b_rdata   = b_rdata_reg;

    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Sequencing controller and two-port arbiter in front of the 64K x 16 behavioural SRAM.
- Accepts word read/write requests from two requesters: port A (CPU) and port B (video/DMA).
- Grants one request at a time and drives the SRAM's active-low CE/OE/WE strobes for the exact wait-state counts the SRAM needs.
- Returns read data to the requester that owns the transaction.

Parameters:
- AW, 16, address width; must match the SRAM address bus.
- DW, 16, data width.
- RD_WAIT, 2, cycles strobes stay asserted for a read (SRAM latches dout on the 2nd edge).
- WR_WAIT, 3, cycles strobes stay asserted for a write (SRAM commits on the 3rd edge).
- RR, 0, 0 = fixed priority A over B; 1 = round-robin when both request.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  AW  port A address.
- a_wdata  in  DW  port A write data.
- a_ack  out  1  one-cycle pulse: request accepted and inputs captured.
- a_rvalid  out  1  one-cycle pulse: a_rdata valid.
- a_rdata  out  DW  port A read data; held until next A read.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: same as port A, for port B.
- sram_ce_n  out  1  SRAM chip enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low; low for BOTH reads and writes (SRAM gates all access on it).
- sram_we_n  out  1  SRAM write enable, active low.
- sram_lb_n, sram_ub_n  out  1  byte lanes; tied 0 (full-word only).
- sram_addr  out  AW  SRAM address.
- sram_din  out  DW  SRAM write data.
- sram_dout  in  DW  SRAM read data (registered inside SRAM).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: sram_ce_n, sram_oe_n, sram_we_n = 1; sram_addr, sram_din = 0; acks and rvalids = 0; rdata = 0; state IDLE; RR pointer = A; owner = A.
- All SRAM outputs come straight from registers, with no combinational path from the req inputs.
- States:
  - IDLE: a request is sampled at edge T0. The arbiter picks a winner and pulses its ack for the cycle after T0. Addr, we and wdata are latched, the owner is recorded, and strobes go low. Next state is RD or WR.
  - RD: the counter runs RD_WAIT cycles. On the edge ending the last one (T0+RD_WAIT), strobes go high and next state is CAP.
  - CAP: strobes stay high (this clears the SRAM's internal counters). sram_dout is captured into the owner's rdata, and its rvalid pulses for the cycle after edge T0+RD_WAIT+1. Next state is IDLE.
  - WR: sram_we_n = 0. The counter runs WR_WAIT cycles. At edge T0+WR_WAIT the SRAM commits; strobes go high and next state is REC.
  - REC: one cycle with strobes high, then IDLE.
- Timing with defaults:
  - Read: accept at T0, rvalid after T3, next accept at T4 (4 cycles per read).
  - Write: accept at T0, commit at T3, next accept at T5 (5 cycles per write).
- Mandatory recovery: CE must never go low for a new transaction without at least one cycle of CE high first. The recovery cycle is never skipped, because the SRAM keeps its count otherwise.
- Arbitration:
  - Evaluated only in IDLE.
  - RR=0: A always wins.
  - RR=1: when both request, the side not granted last wins; the pointer updates on every grant.
  - A single requester always wins immediately.
- Non-winners keep their request pending: no ack, inputs ignored until granted.
- Requester inputs may change freely after ack. A requester dropping req before ack simply withdraws.
- Read data goes only to the owner; the other port's rdata and rvalid stay unchanged.
- Counter width is clog2(max(RD_WAIT, WR_WAIT)+1). The counter resets to 0 on every state entry.
- Reset asserted mid-transaction: synchronous return to reset values at the next edge. No rvalid is issued. A partially sequenced write is aborted; the SRAM drops it because CE goes high before its count completes.

Decomposition:
- Shared defines file: state encodings (IDLE, RD, CAP, WR, REC), default RD_WAIT/WR_WAIT, and the SRAM AW/DW constants, so the SRAM model and controller agree.
- One natural sub-module: sram_arb. It takes two reqs, RR mode and the grant strobe, and produces a one-hot grant plus a last-grant pointer. The FSM, counter and datapath stay in sram_ctrl.

Test Plan:
- Write then read, A only: A writes 16'hBEEF to 16'h0010, then reads 16'h0010. a_ack after T0; SRAM array[16'h0010] = BEEF after T3; read a_rvalid 3 cycles after its accept, with a_rdata = BEEF.
- Strobe timing: one read and one write. sram_ce_n/oe_n low for exactly 2 (read) and 3 (write) cycles, sram_we_n low only during the write, and at least 1 cycle of CE high between transactions.
- Simultaneous requests, RR=0: A and B both read 16'h0001 and 16'h0002 (contents 1111/2222) continuously. All grants go to A until A drops, then B; b_rdata = 2222 and a_rdata unchanged.
- Simultaneous requests, RR=1: both ports request continuously. Grants alternate A,B,A,B; each port's rvalid carries its own address's data.
- Back-to-back reads on A, 8 addresses: a_ack pulses exactly 4 cycles apart; data correct in order, with no stale SRAM count (no early or late data).
- Reset during WR after 2 strobe cycles: outputs return to reset values next edge; target word keeps its old value; the next request after reset completes normally.
